// File: rtl/alu_issue_stage.sv
// alu_issue_stage: decodes MIPS-style op fields, drives a combinational ALU and returns its result.
// Latency: 2 cycles. An op accepted at edge N is presented on res_* after edge N+1. One op per cycle sustained.
// Backpressure: res_ready low holds S2. S1 holds once S2 is full. iss_ready drops only when both stages are full and res_ready is low.
//
// Ports:
//   clk, reset                     rising-edge clock, async active-high reset
//   iss_*                          issue handshake plus decoded instruction fields, rs/rt values and tag
//   alu_in0/in1/shamt/op           registered S1 operands to the external ALU
//   alu_out, alu_iszero            combinational ALU result, captured into S2
//   res_*                          result handshake: data, zero flag, tag, illegal flag
//   retired                        wrapping count of results accepted downstream
module alu_issue_stage #(
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             iss_valid,
  output logic             iss_ready,
  input  logic [5:0]       iss_opcode,
  input  logic [5:0]       iss_funct,
  input  logic [4:0]       iss_shamt,
  input  logic [15:0]      iss_imm,
  input  logic [31:0]      iss_rs,
  input  logic [31:0]      iss_rt,
  input  logic [TAG_W-1:0] iss_tag,
  output logic [31:0]      alu_in0,
  output logic [31:0]      alu_in1,
  output logic [5:0]       alu_shamt,
  output logic [3:0]       alu_op,
  input  logic [31:0]      alu_out,
  input  logic             alu_iszero,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [31:0]      res_data,
  output logic             res_zero,
  output logic [TAG_W-1:0] res_tag,
  output logic             res_illegal,
  output logic [31:0]      retired
);

  logic             s1_valid;
  logic             s2_valid;
  logic [TAG_W-1:0] s1_tag;
  logic             s1_illegal;
  logic             s2_adv;
  logic             accept;

  logic [3:0]  d_op;
  logic [31:0] d_in0;
  logic [31:0] d_in1;
  logic [5:0]  d_shamt;
  logic        d_ill;

  assign s2_adv    = s1_valid && (!s2_valid || res_ready);
  assign iss_ready = !s1_valid || s2_adv;
  assign accept    = iss_valid && iss_ready;
  assign res_valid = s2_valid;

  // Decode. Unknown encodings fall through to op 1111 with zeroed operands.
  always_comb begin
    d_op    = 4'hF;
    d_in0   = iss_rs;
    d_in1   = iss_rt;
    d_shamt = 6'd0;
    d_ill   = 1'b0;
    if (iss_opcode == 6'h00) begin
      d_shamt = {1'b0, iss_shamt};
      case (iss_funct)
        6'h24:        d_op = 4'b0000;
        6'h25:        d_op = 4'b0001;
        6'h20, 6'h21: d_op = 4'b0010;
        6'h00:        d_op = 4'b0100;
        6'h02:        d_op = 4'b0101;
        6'h22, 6'h23: d_op = 4'b0110;
        6'h2A:        d_op = 4'b0111;
        6'h27:        d_op = 4'b1100;
        default:      d_ill = 1'b1;
      endcase
    end else begin
      case (iss_opcode)
        6'h08, 6'h09: begin d_op = 4'b0010; d_in1 = {{16{iss_imm[15]}}, iss_imm}; end
        6'h0A:        begin d_op = 4'b0111; d_in1 = {{16{iss_imm[15]}}, iss_imm}; end
        6'h0C:        begin d_op = 4'b0000; d_in1 = {16'd0, iss_imm}; end
        6'h0D:        begin d_op = 4'b0001; d_in1 = {16'd0, iss_imm}; end
        6'h04:        d_op = 4'b0110;
        default:      d_ill = 1'b1;
      endcase
    end
    if (d_ill) begin
      d_op    = 4'hF;
      d_in0   = 32'd0;
      d_in1   = 32'd0;
      d_shamt = 6'd0;
    end
  end

  // S1: ALU ports come straight from these registers, so they only move on accept.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid   <= 1'b0;
      alu_in0    <= 32'd0;
      alu_in1    <= 32'd0;
      alu_shamt  <= 6'd0;
      alu_op     <= 4'd0;
      s1_tag     <= '0;
      s1_illegal <= 1'b0;
    end else begin
      if (accept) begin
        s1_valid   <= 1'b1;
        alu_in0    <= d_in0;
        alu_in1    <= d_in1;
        alu_shamt  <= d_shamt;
        alu_op     <= d_op;
        s1_tag     <= iss_tag;
        s1_illegal <= d_ill;
      end else if (s2_adv) begin
        s1_valid <= 1'b0;
      end
    end
  end

  // S2: illegal ops ignore whatever the ALU produces and report zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s2_valid    <= 1'b0;
      res_data    <= 32'd0;
      res_zero    <= 1'b0;
      res_tag     <= '0;
      res_illegal <= 1'b0;
      retired     <= 32'd0;
    end else begin
      if (s2_adv) begin
        s2_valid    <= 1'b1;
        res_data    <= s1_illegal ? 32'd0 : alu_out;
        res_zero    <= s1_illegal | alu_iszero;
        res_tag     <= s1_tag;
        res_illegal <= s1_illegal;
      end else if (res_ready) begin
        s2_valid <= 1'b0;
      end
      if (s2_valid && res_ready) retired <= retired + 32'd1;
    end
  end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Initiator side of the ALU operand/opcode interface. Accepts decoded MIPS-style instruction fields through a valid/ready handshake.
- Translates opcode/funct to the 4-bit ALU op and drives registered operands, shamt and op into the combinational ALU.
- Captures ALU out/iszero into a result register and returns them downstream through a second valid/ready handshake.
- Sits between register-read and writeback/branch-resolve in the core: a 2-stage, fully backpressured pipeline.

Parameters:
- TAG_W, 5, width of the destination tag carried alongside each operation.

Ports:
- clk, input, 1, clock; all state updates on the rising edge.
- reset, input, 1, asynchronous, active-high reset.
- iss_valid, input, 1, upstream presents an operation.
- iss_ready, output, 1, block accepts the operation this cycle.
- iss_opcode, input, 6, primary opcode field.
- iss_funct, input, 6, funct field; used only when iss_opcode==0.
- iss_shamt, input, 5, shift amount field.
- iss_imm, input, 16, immediate field.
- iss_rs, input, 32, rs register value.
- iss_rt, input, 32, rt register value.
- iss_tag, input, TAG_W, destination tag.
- alu_in0, output, 32, to ALU in0.
- alu_in1, output, 32, to ALU in1.
- alu_shamt, output, 6, to ALU shamt.
- alu_op, output, 4, to ALU op.
- alu_out, input, 32, from ALU result.
- alu_iszero, input, 1, from ALU zero flag.
- res_valid, output, 1, result available.
- res_ready, input, 1, downstream accepts the result.
- res_data, output, 32, captured ALU result.
- res_zero, output, 1, captured zero flag.
- res_tag, output, TAG_W, tag of the result.
- res_illegal, output, 1, operation was undecodable.
- retired, output, 32, count of results accepted downstream.

Behaviour:
- Reset: s1_valid=0, s2_valid=0. alu_in0/in1/shamt/op=0, res_data=0, res_zero=0, res_tag=0, res_illegal=0, retired=0.
- Reset is effective immediately regardless of clk. Operations in flight at reset are discarded, not completed.
- Stage 1 (S1): registered ALU inputs plus tag and illegal flag. The ALU ports are driven directly from S1 registers.
- Stage 2 (S2): registered alu_out, alu_iszero, tag, illegal.
- Advance rules:
  - s2_adv = s1_valid && (!s2_valid || res_ready).
  - iss_ready = !s1_valid || s2_adv (combinational, no dependence on iss_valid).
  - Accept = iss_valid && iss_ready.
- Latency and throughput: accepted at edge N → res_valid high after edge N+1 (two registered stages, result visible the cycle after S1 is loaded). Sustained throughput is one operation per cycle with res_ready held high.
- Stalls:
  - res_ready low holds S2 stable (data, zero, tag, illegal unchanged).
  - S1 holds once S2 is full; ALU ports must not change while S1 is stalled.
  - iss_ready drops only when both stages are full and res_ready=0.
- Simultaneous events: S2 drain, S1→S2 move and a new accept in the same cycle are all legal and lossless.
- Decode when iss_opcode==0 (R-type):
  - Funct 0x24 → op 0000.
  - Funct 0x25 → 0001.
  - Funct 0x20/0x21 → 0010.
  - Funct 0x00 → 0100.
  - Funct 0x02 → 0101.
  - Funct 0x22/0x23 → 0110.
  - Funct 0x2A → 0111.
  - Funct 0x27 → 1100.
  - in0=rs, in1=rt.
  - shamt = {1'b0, iss_shamt} for every R-type op (ignored by the ALU for non-shifts).
- Decode for I-type opcodes:
  - 0x08/0x09 → 0010, in1 = sign-extended imm.
  - 0x0A → 0111, in1 = sign-extended imm.
  - 0x0C → 0000, in1 = zero-extended imm.
  - 0x0D → 0001, in1 = zero-extended imm.
  - 0x04 (BEQ) → 0110, in1 = rt.
  - in0=rs, shamt=0.
- Illegal operations:
  - Any other opcode or funct → op 1111, in0=in1=0, illegal=1.
  - The operation still flows through and returns res_data=0, res_zero=1, with its tag.
- SLT/SLTI compare is whatever the ALU computes (unsigned); this block does not correct it.
- retired increments by 1 on each res_valid && res_ready and wraps from 0xFFFFFFFF to 0.

Test Plan:
- Reset, then ADD: opcode 0, funct 0x20, rs=5, rt=7, tag 3 → alu_op=0010 one cycle after accept; res_valid with res_data=12, res_zero=0, res_tag=3; retired=1 after handshake.
- BEQ opcode 0x04, rs=rt=0x1234 → alu_op=0110, res_data=0, res_zero=1. Then ADDI imm 0xFFFF, rs=1 → res_data=0.
- Back-to-back: SLL (shamt 4, rt=1), ORI (imm 0x00F0, rs=0x0F), NOR (rs=rt=0) with res_ready=1 → results 0x10, 0xFF, 0xFFFFFFFF on consecutive cycles, tags in order, iss_ready never low.
- Backpressure: res_ready=0 while issuing 3 ops → iss_ready low after 2 accepts, S2 contents stable. Then res_ready=1 → all 3 results delivered in order with no duplicates.
- Illegal opcode 0x3F, tag 9 → res_illegal=1, res_data=0, res_zero=1, res_tag=9. The next legal op has res_illegal=0.
- Assert reset asynchronously with both stages full → res_valid and all outputs 0 before the next clk edge; retired=0; the first post-reset op behaves as in the first scenario.
